// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cache_pkg
//  Description : Shared FSM state encoding and replacement-policy constants
//                for the N-way read cache.
//  Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_lookup = 2'd1;
    localparam logic [1:0] c_st_fetch  = 2'd2;
    localparam logic [1:0] c_st_fill   = 2'd3;

    localparam int REPL_LRU = 0;
    localparam int REPL_RR  = 1;

    // A direct-mapped cache still needs a 1-bit way index to keep ports legal.
    function automatic int way_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_repl_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cache_repl_ctrl
//  Description : Per-set replacement state (true LRU ages or round-robin
//                pointer) and victim-way selection.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_repl_ctrl
    import cache_pkg::*;
#(
    parameter  int NUM_WAYS    = 2,
    parameter  int NUM_SETS    = 16,
    parameter  int REPL_POLICY = REPL_LRU,
    localparam int IDX_W       = $clog2(NUM_SETS),
    localparam int WAY_W       = way_w(NUM_WAYS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_W-1:0]    set_idx,
    input  logic [NUM_WAYS-1:0] valid_bits,
    input  logic                touch,
    input  logic [WAY_W-1:0]    touch_way,
    input  logic                advance,
    output logic [WAY_W-1:0]    victim
);

    logic [WAY_W-1:0] w_policy_way;
    logic [WAY_W-1:0] w_free_way;
    logic             w_any_free;

    // Descending scan so the lowest-numbered invalid way wins.
    always_comb begin
        w_any_free = 1'b0;
        w_free_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_bits[w]) begin
                w_any_free = 1'b1;
                w_free_way = WAY_W'(w);
            end
        end
    end

    assign victim = w_any_free ? w_free_way : w_policy_way;

    if (NUM_WAYS == 1) begin : g_direct
        logic w_unused;
        assign w_unused     = &{1'b0, clk, rst, set_idx, touch, touch_way, advance};
        assign w_policy_way = '0;
    end else if (REPL_POLICY == REPL_RR) begin : g_rr
        logic             w_unused;
        logic [WAY_W-1:0] r_ptr [NUM_SETS];

        assign w_unused = &{1'b0, touch, touch_way};

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int s = 0; s < NUM_SETS; s++) r_ptr[s] <= '0;
            end else if (advance) begin
                r_ptr[set_idx] <= r_ptr[set_idx] + WAY_W'(1);
            end
        end

        assign w_policy_way = r_ptr[set_idx];
    end else begin : g_lru
        logic             w_unused;
        logic [WAY_W-1:0] r_age [NUM_SETS][NUM_WAYS];

        assign w_unused = &{1'b0, advance};

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int s = 0; s < NUM_SETS; s++)
                    for (int w = 0; w < NUM_WAYS; w++)
                        r_age[s][w] <= WAY_W'(w);
            end else if (touch) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    if (WAY_W'(w) == touch_way)
                        r_age[set_idx][w] <= '0;
                    else if (r_age[set_idx][w] < r_age[set_idx][touch_way])
                        r_age[set_idx][w] <= r_age[set_idx][w] + WAY_W'(1);
                end
            end
        end

        always_comb begin
            w_policy_way = '0;
            for (int w = 0; w < NUM_WAYS; w++)
                if (r_age[set_idx][w] == WAY_W'(NUM_WAYS - 1))
                    w_policy_way = WAY_W'(w);
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_system_nway.sv
`default_nettype none
// ============================================================================
//  Module      : cache_system_nway
//  Description : Set-associative one-word-line read cache with backing fetch
//                interface and access/hit statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_system_nway
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH  = 11,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_WAYS    = 2,
    parameter int NUM_SETS    = 16,
    parameter int REPL_POLICY = REPL_LRU,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  hit,
    output logic                  done,
    output logic                  busy,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    input  logic                  clear_stats,
    output logic [CNT_WIDTH-1:0]  access_count,
    output logic [CNT_WIDTH-1:0]  hit_count
);

    localparam int c_idx_w = $clog2(NUM_SETS);
    localparam int c_tag_w = ADDR_WIDTH - c_idx_w;
    localparam int c_way_w = way_w(NUM_WAYS);

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_fill_data;
    logic [DATA_WIDTH-1:0] r_read_data;
    logic                  r_hit;
    logic                  r_done;
    logic                  r_busy;
    logic                  r_mem_req;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [CNT_WIDTH-1:0]  r_access_count;
    logic [CNT_WIDTH-1:0]  r_hit_count;

    logic [NUM_WAYS-1:0]   r_valid [NUM_SETS];
    logic [c_tag_w-1:0]    r_tag   [NUM_SETS][NUM_WAYS];
    logic [DATA_WIDTH-1:0] r_data  [NUM_SETS][NUM_WAYS];

    logic [c_idx_w-1:0]    w_idx;
    logic [c_tag_w-1:0]    w_tag;
    logic                  w_hit;
    logic [c_way_w-1:0]    w_hit_way;
    logic [DATA_WIDTH-1:0] w_hit_data;
    logic [c_way_w-1:0]    w_victim;
    logic                  w_fill;
    logic                  w_touch;
    logic [c_way_w-1:0]    w_touch_way;
    logic                  w_advance;

    assign w_idx = r_addr[c_idx_w-1:0];
    assign w_tag = r_addr[ADDR_WIDTH-1:c_idx_w];

    always_comb begin
        w_hit      = 1'b0;
        w_hit_way  = '0;
        w_hit_data = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (r_valid[w_idx][w] && r_tag[w_idx][w] == w_tag) begin
                w_hit      = 1'b1;
                w_hit_way  = c_way_w'(w);
                w_hit_data = r_data[w_idx][w];
            end
        end
    end

    assign w_fill      = (r_state == c_st_fill);
    assign w_touch     = w_fill || (r_state == c_st_lookup && w_hit);
    assign w_touch_way = w_fill ? w_victim : w_hit_way;
    // Round-robin only moves when a live line was evicted.
    assign w_advance   = w_fill && r_valid[w_idx][w_victim];

    cache_repl_ctrl #(
        .NUM_WAYS    (NUM_WAYS),
        .NUM_SETS    (NUM_SETS),
        .REPL_POLICY (REPL_POLICY)
    ) u_repl (
        .clk        (clk),
        .rst        (rst),
        .set_idx    (w_idx),
        .valid_bits (r_valid[w_idx]),
        .touch      (w_touch),
        .touch_way  (w_touch_way),
        .advance    (w_advance),
        .victim     (w_victim)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_addr      <= '0;
            r_fill_data <= '0;
            r_read_data <= '0;
            r_hit       <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            for (int s = 0; s < NUM_SETS; s++) r_valid[s] <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    // busy stays up through the done cycle, then drops.
                    if (r_done) begin
                        r_busy <= 1'b0;
                    end else if (read && !r_busy) begin
                        r_addr  <= addr;
                        r_busy  <= 1'b1;
                        r_state <= c_st_lookup;
                    end
                end
                c_st_lookup: begin
                    if (w_hit) begin
                        r_read_data <= w_hit_data;
                        r_hit       <= 1'b1;
                        r_done      <= 1'b1;
                        r_state     <= c_st_idle;
                    end else begin
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= r_addr;
                        r_state    <= c_st_fetch;
                    end
                end
                c_st_fetch: begin
                    if (mem_ready) begin
                        r_fill_data <= mem_rdata;
                        r_mem_req   <= 1'b0;
                        r_state     <= c_st_fill;
                    end
                end
                c_st_fill: begin
                    r_valid[w_idx][w_victim] <= 1'b1;
                    r_read_data <= r_fill_data;
                    r_hit       <= 1'b0;
                    r_done      <= 1'b1;
                    r_state     <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_fill) begin
            r_tag[w_idx][w_victim]  <= w_tag;
            r_data[w_idx][w_victim] <= r_fill_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_stats) begin
            r_access_count <= '0;
            r_hit_count    <= '0;
        end else if (r_done) begin
            if (~&r_access_count) r_access_count <= r_access_count + CNT_WIDTH'(1);
            if (r_hit && ~&r_hit_count) r_hit_count <= r_hit_count + CNT_WIDTH'(1);
        end
    end

    assign read_data    = r_read_data;
    assign hit          = r_hit;
    assign done         = r_done;
    assign busy         = r_busy;
    assign mem_req      = r_mem_req;
    assign mem_addr     = r_mem_addr;
    assign access_count = r_access_count;
    assign hit_count    = r_hit_count;

endmodule
`default_nettype wire
